// File: rtl/axis_overflow_guard_pkg.sv
// -----------------------------------------------------------------------------
// axis_overflow_guard_pkg
//   Shared types and constants for the AXI4-Stream overflow guard.
//   - guard_state_t : forwarding state (ST_PASS forwards, ST_DROP discards)
//   - resume_cnt_t  : resume counter type, wide enough for RESUME_CYCLES <= 255
// -----------------------------------------------------------------------------
package axis_overflow_guard_pkg;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } guard_state_t;

    localparam int unsigned RESUME_CNT_WIDTH = 8;

    typedef logic [RESUME_CNT_WIDTH-1:0] resume_cnt_t;

endpackage

// File: rtl/axis_overflow_guard_if.sv
// -----------------------------------------------------------------------------
// axis_overflow_guard_if
//   Minimal AXI4-Stream handshake bundle (tdata/tvalid/tready).
//   - master modport : drives tdata/tvalid, receives tready
//   - slave modport  : receives tdata/tvalid, drives tready
// -----------------------------------------------------------------------------
interface axis_overflow_guard_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/axis_overflow_guard_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for the guard's status counters.
//   Ports:
//     aclk, aresetn : clock, synchronous active-low reset
//     inc           : count one event this cycle
//     clr           : zero the counter; wins over a simultaneous inc
//     cnt           : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge aclk) begin
        if (!aresetn || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/axis_overflow_guard.sv
// -----------------------------------------------------------------------------
// axis_overflow_guard
//   Non-stallable AXI4-Stream guard between a free-running sample source and a
//   downstream writer. Input is always accepted; samples are forwarded through
//   a one-entry output register. If a sample arrives while the output register
//   is full and not being consumed, it is lost and the guard enters DROP,
//   discarding all input until the consumer has been ready with the output
//   register empty for RESUME_CYCLES consecutive cycles.
//   Ports:
//     aclk, aresetn        : clock, synchronous active-low reset
//     s_axis (slave)       : sample input, tready high every cycle after reset
//     m_axis (master)      : registered sample output
//     clear                : pulse, zeroes overflow and all counters
//     overflow             : sticky, set by the first lost sample
//     dropping             : high while in DROP
//     lost_cnt             : samples discarded
//     event_cnt            : PASS->DROP transitions
//     pass_cnt             : samples delivered on m_axis
// -----------------------------------------------------------------------------
module axis_overflow_guard
    import axis_overflow_guard_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CNTR_WIDTH       = 32,
    parameter int unsigned RESUME_CYCLES    = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axis_overflow_guard_if.slave  s_axis,
    axis_overflow_guard_if.master m_axis,
    input  logic                  clear,
    output logic                  overflow,
    output logic                  dropping,
    output logic [CNTR_WIDTH-1:0] lost_cnt,
    output logic [CNTR_WIDTH-1:0] event_cnt,
    output logic [CNTR_WIDTH-1:0] pass_cnt
);

    localparam resume_cnt_t RESUME_TARGET = resume_cnt_t'(RESUME_CYCLES);

    guard_state_t                state_q, state_d;
    resume_cnt_t                 resume_q, resume_d;

    logic                        ready_q;
    logic                        tvalid_q;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q;
    logic                        overflow_q;

    logic                        in_beat;
    logic                        or_free;
    logic                        or_consume;
    logic                        drain_cycle;
    logic                        load;
    logic                        lose;
    logic                        new_event;

    // Handshake decode
    assign in_beat     = s_axis.tvalid & ready_q;
    assign or_consume  = tvalid_q & m_axis.tready;
    // Output register can take a new sample: empty, or emptying this cycle
    assign or_free     = ~tvalid_q | m_axis.tready;
    // Consumer ready with nothing pending: counts toward resuming
    assign drain_cycle = ~tvalid_q & m_axis.tready;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_PASS;
            resume_q <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        resume_d = '0;
        unique case (state_q)
            ST_PASS: begin
                if (in_beat && !or_free) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                // The cycle in which the count is seen complete is itself
                // still a DROP cycle; forwarding restarts the cycle after.
                if (resume_q == RESUME_TARGET) begin
                    state_d = ST_PASS;
                end else if (drain_cycle) begin
                    resume_d = resume_q + resume_cnt_t'(1);
                end
            end
            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        load      = 1'b0;
        lose      = 1'b0;
        new_event = 1'b0;
        dropping  = 1'b0;
        unique case (state_q)
            ST_PASS: begin
                load      = in_beat & or_free;
                lose      = in_beat & ~or_free;
                new_event = in_beat & ~or_free;
            end
            ST_DROP: begin
                lose     = in_beat;
                dropping = 1'b1;
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: ready, output register, sticky overflow
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ready_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;

            if (load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= s_axis.tdata;
            end else if (or_consume) begin
                tvalid_q <= 1'b0;
            end

            if (clear) begin
                overflow_q <= 1'b0;
            end else if (lose) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign s_axis.tready = ready_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign overflow      = overflow_q;

    // -------------------------------------------------------------------------
    // Status counters
    // -------------------------------------------------------------------------
    sat_counter #(.WIDTH(CNTR_WIDTH)) u_lost_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (lose),
        .clr     (clear),
        .cnt     (lost_cnt)
    );

    sat_counter #(.WIDTH(CNTR_WIDTH)) u_event_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (new_event),
        .clr     (clear),
        .cnt     (event_cnt)
    );

    sat_counter #(.WIDTH(CNTR_WIDTH)) u_pass_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (or_consume),
        .clr     (clear),
        .cnt     (pass_cnt)
    );

endmodule

// File: tb/tb_axis_overflow_guard.sv
// -----------------------------------------------------------------------------
// tb_axis_overflow_guard
//   Directed self-checking bench for axis_overflow_guard. Counters are built
//   8 bits wide so that saturation is reachable with a short drop burst.
// -----------------------------------------------------------------------------
module tb_axis_overflow_guard;

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 8;
    localparam int unsigned RES = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          clear;
    logic          overflow;
    logic          dropping;
    logic [CW-1:0] lost_cnt;
    logic [CW-1:0] event_cnt;
    logic [CW-1:0] pass_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    axis_overflow_guard_if #(.DATA_WIDTH(DW)) s_if ();
    axis_overflow_guard_if #(.DATA_WIDTH(DW)) m_if ();

    axis_overflow_guard #(
        .AXIS_TDATA_WIDTH (DW),
        .CNTR_WIDTH       (CW),
        .RESUME_CYCLES    (RES)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .clear     (clear),
        .overflow  (overflow),
        .dropping  (dropping),
        .lost_cnt  (lost_cnt),
        .event_cnt (event_cnt),
        .pass_cnt  (pass_cnt)
    );

    always #5 aclk = ~aclk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        aresetn     = 1'b0;
        clear       = 1'b0;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_m_tdata",  64'(m_if.tdata),  64'd0);
        check("rst_overflow", 64'(overflow),    64'd0);
        check("rst_dropping", 64'(dropping),    64'd0);
        check("rst_lost",     64'(lost_cnt),    64'd0);
        check("rst_event",    64'(event_cnt),   64'd0);
        check("rst_pass",     64'(pass_cnt),    64'd0);

        aresetn = 1'b1;
        tick();
        check("s_tready_up", 64'(s_if.tready), 64'd1);

        // ---------------- streaming 0x1..0x10 ----------------
        m_if.tready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_if.tdata  = DW'(i);
            s_if.tvalid = 1'b1;
            tick();
            check("stream_tvalid", 64'(m_if.tvalid), 64'd1);
            check("stream_tdata",  64'(m_if.tdata),  64'(i));
        end
        s_if.tvalid = 1'b0;
        tick();
        check("stream_drained", 64'(m_if.tvalid), 64'd0);
        check("stream_pass",    64'(pass_cnt),    64'd16);
        check("stream_ovf",     64'(overflow),    64'd0);
        check("stream_lost",    64'(lost_cnt),    64'd0);

        // ---------------- back-pressure without beats ----------------
        m_if.tready = 1'b0;
        s_if.tdata  = 32'h55;
        s_if.tvalid = 1'b1;
        tick();
        s_if.tvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_tvalid", 64'(m_if.tvalid), 64'd1);
            check("bp_hold_tdata",  64'(m_if.tdata),  64'h55);
        end
        m_if.tready = 1'b1;
        tick();
        check("bp_release_tvalid", 64'(m_if.tvalid), 64'd0);
        check("bp_event",          64'(event_cnt),   64'd0);
        check("bp_lost",           64'(lost_cnt),    64'd0);
        check("bp_pass",           64'(pass_cnt),    64'd17);
        check("bp_dropping",       64'(dropping),    64'd0);

        // ---------------- overflow and resume ----------------
        m_if.tready = 1'b0;
        s_if.tdata  = 32'hA;
        s_if.tvalid = 1'b1;
        tick();
        check("ovf_fill_A", 64'(m_if.tdata), 64'hA);
        for (int i = 'hB; i <= 'hE; i++) begin
            s_if.tdata = DW'(i);
            tick();
        end
        check("ovf_dropping", 64'(dropping),    64'd1);
        check("ovf_sticky",   64'(overflow),    64'd1);
        check("ovf_event",    64'(event_cnt),   64'd1);
        check("ovf_lost4",    64'(lost_cnt),    64'd4);
        check("ovf_hold_A",   64'(m_if.tdata),  64'hA);
        check("ovf_hold_vld", 64'(m_if.tvalid), 64'd1);

        // drain cycle, 4 resume cycles, transition cycle: all dropped
        m_if.tready = 1'b1;
        for (int j = 0; j <= 6; j++) begin
            s_if.tdata = DW'(32'h20 + j);
            tick();
            if (j == 0) begin
                check("res_A_delivered", 64'(m_if.tvalid), 64'd0);
                check("res_pass18",      64'(pass_cnt),    64'd18);
            end
            if (j == 4) check("res_still_drop", 64'(dropping), 64'd1);
            if (j == 5) check("res_back_pass",  64'(dropping), 64'd0);
        end
        check("res_first_fwd_vld", 64'(m_if.tvalid), 64'd1);
        check("res_first_fwd",     64'(m_if.tdata),  64'h26);
        check("res_lost10",        64'(lost_cnt),    64'd10);
        check("res_event1",        64'(event_cnt),   64'd1);
        check("res_ovf",           64'(overflow),    64'd1);
        s_if.tvalid = 1'b0;
        tick();
        check("res_pass19", 64'(pass_cnt), 64'd19);

        // ---------------- interrupted resume run ----------------
        m_if.tready = 1'b0;
        s_if.tdata  = 32'h30;
        s_if.tvalid = 1'b1;
        tick();
        s_if.tdata = 32'h31;
        tick();
        s_if.tvalid = 1'b0;
        check("tog_event2",   64'(event_cnt), 64'd2);
        check("tog_lost11",   64'(lost_cnt),  64'd11);
        m_if.tready = 1'b1;
        tick();
        check("tog_drain_pass", 64'(pass_cnt), 64'd20);
        begin
            logic [7:0] pattern;
            pattern = 8'b1110_1111;  // applied MSB first: 1,1,1,0,1,1,1,1
            for (int k = 7; k >= 0; k--) begin
                m_if.tready = pattern[k];
                tick();
                check("tog_dropping", 64'(dropping), 64'd1);
            end
        end
        m_if.tready = 1'b1;
        tick();
        check("tog_resumed", 64'(dropping), 64'd0);

        // ---------------- clear vs simultaneous loss ----------------
        m_if.tready = 1'b0;
        s_if.tdata  = 32'h40;
        s_if.tvalid = 1'b1;
        tick();
        s_if.tdata = 32'h41;
        clear      = 1'b1;
        tick();
        clear       = 1'b0;
        s_if.tvalid = 1'b0;
        check("clr_lost",     64'(lost_cnt),    64'd0);
        check("clr_event",    64'(event_cnt),   64'd0);
        check("clr_pass",     64'(pass_cnt),    64'd0);
        check("clr_overflow", 64'(overflow),    64'd0);
        check("clr_dropping", 64'(dropping),    64'd1);
        check("clr_or_vld",   64'(m_if.tvalid), 64'd1);
        check("clr_or_data",  64'(m_if.tdata),  64'h40);

        // ---------------- lost_cnt saturation ----------------
        s_if.tdata  = 32'h99;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        check("sat_reach", 64'(lost_cnt), 64'd255);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_hold", 64'(lost_cnt), 64'd255);
        end
        check("sat_event", 64'(event_cnt), 64'd0);

        // ---------------- reset in DROP with OR full ----------------
        check("pre_rst_dropping", 64'(dropping),    64'd1);
        check("pre_rst_or_vld",   64'(m_if.tvalid), 64'd1);
        aresetn = 1'b0;
        tick();
        check("mid_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("mid_rst_s_tready", 64'(s_if.tready), 64'd0);
        check("mid_rst_dropping", 64'(dropping),    64'd0);
        check("mid_rst_overflow", 64'(overflow),    64'd0);
        check("mid_rst_lost",     64'(lost_cnt),    64'd0);
        check("mid_rst_event",    64'(event_cnt),   64'd0);
        check("mid_rst_pass",     64'(pass_cnt),    64'd0);
        check("mid_rst_m_tdata",  64'(m_if.tdata),  64'd0);

        aresetn     = 1'b1;
        s_if.tvalid = 1'b0;
        tick();
        s_if.tdata  = 32'h77;
        s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        tick();
        s_if.tvalid = 1'b0;
        check("post_rst_vld",  64'(m_if.tvalid), 64'd1);
        check("post_rst_data", 64'(m_if.tdata),  64'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
